// File: rtl/vram_write_responder.sv
// Burst write responder: fetches words from an initiator one at a time and
// issues them as single memory writes across a wrapping address window.
module vram_write_responder #(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned LEN_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrLoad,
    input  logic [ADDR_W-1:0] wrMinAddr,
    input  logic [ADDR_W-1:0] wrMaxAddr,
    input  logic [LEN_W-1:0]  wrLength,
    input  logic [31:0]       wrData,
    output logic              wrReq,
    output logic              wrDone,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memData,
    input  logic              memAck,
    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StReq,
        StCapt,
        StWrite,
        StDone
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] min_q;
    logic [ADDR_W-1:0] max_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [31:0]       data_q;
    logic              wr_req_q;
    logic              wr_done_q;
    logic              mem_req_q;
    logic              busy_q;

    logic [LEN_W-1:0]  cnt_inc;
    logic [ADDR_W:0]   addr_inc;
    logic [ADDR_W-1:0] addr_next;

    // Next write address: step by one, wrap to the window start at the bound.
    // One extra bit keeps the compare correct when addr is all-ones.
    always_comb begin
        cnt_inc  = cnt_q + LEN_W'(1);
        addr_inc = {1'b0, addr_q} + (ADDR_W + 1)'(1);
        if (addr_inc >= {1'b0, max_q}) begin
            addr_next = min_q;
        end else begin
            addr_next = addr_inc[ADDR_W-1:0];
        end
    end

    // Burst sequencer with registered handshake outputs; wrLoad always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            min_q     <= '0;
            max_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            wr_req_q  <= 1'b0;
            wr_done_q <= 1'b0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wr_req_q  <= 1'b0;
            wr_done_q <= 1'b0;
            if (wrLoad) begin
                // Start or restart: re-latch the window, drop any pending write.
                state_q   <= StArm;
                min_q     <= wrMinAddr;
                addr_q    <= wrMinAddr;
                max_q     <= wrMaxAddr;
                mem_req_q <= 1'b0;
                busy_q    <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                    StArm: begin
                        len_q <= wrLength;
                        cnt_q <= '0;
                        if (wrLength == '0) begin
                            state_q   <= StDone;
                            wr_done_q <= 1'b1;
                        end else begin
                            state_q  <= StReq;
                            wr_req_q <= 1'b1;
                        end
                    end
                    StReq: begin
                        state_q <= StCapt;
                    end
                    StCapt: begin
                        // Initiator data is valid the cycle after wrReq.
                        data_q    <= wrData;
                        mem_req_q <= 1'b1;
                        state_q   <= StWrite;
                    end
                    StWrite: begin
                        if (memAck) begin
                            mem_req_q <= 1'b0;
                            cnt_q     <= cnt_inc;
                            addr_q    <= addr_next;
                            if (cnt_inc == len_q) begin
                                state_q   <= StDone;
                                wr_done_q <= 1'b1;
                            end else begin
                                state_q  <= StReq;
                                wr_req_q <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wrReq   = wr_req_q;
    assign wrDone  = wr_done_q;
    assign memReq  = mem_req_q;
    assign memAddr = addr_q;
    assign memData = data_q;
    assign busy    = busy_q;

endmodule
